// File: rtl/kf_pkg.sv
// kf_pkg: shared types and constants for the Kalman-filter time-parameter
// generator (state encoding, IEEE-754 double constants, multiplier latency).
package kf_pkg;

   localparam int unsigned DBL_W = 64;

   localparam logic [DBL_W-1:0] FP_HALF = 64'h3FE0000000000000;
   localparam logic [DBL_W-1:0] FP_ONE  = 64'h3FF0000000000000;
   localparam logic [DBL_W-1:0] FP_ZERO = 64'h0000000000000000;

   // Cycles from the multiplier valid pulse to its finish pulse (must be >= 1).
   localparam int unsigned MUL_LATENCY = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQ_ISSUE,
      S_SQ_WAIT,
      S_HALF_ISSUE,
      S_HALF_WAIT,
      S_CUBE_ISSUE,
      S_CUBE_WAIT,
      S_DONE
   } kf_tpg_state_e;

endpackage

// File: rtl/fp_multiplier.sv
// fp_multiplier: shared IEEE-754 double multiplier with a valid/ready/finish
// handshake. One operation in flight; ready drops while busy and finish pulses
// for one cycle LATENCY cycles after the accepted valid. Round to nearest even;
// subnormal inputs and underflowing results are flushed to signed zero.
module fp_multiplier
   import kf_pkg::*;
#(
   parameter int unsigned LATENCY = MUL_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DBL_W-1:0]  a_i,
   input  logic [DBL_W-1:0]  b_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              finish_o,
   output logic [DBL_W-1:0]  result_o
);

   logic               sa, sb, s_res;
   logic [10:0]        ea, eb;
   logic [51:0]        fa, fb;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [105:0]       prod;
   logic [51:0]        frac_t;
   logic               grd, stk, rnd, carry;
   logic [51:0]        frac_r;
   logic signed [13:0] exp_s;
   logic [DBL_W-1:0]   res_d, res_q;
   logic               busy_q;
   logic [7:0]         cnt_q;

   // Combinational double-precision product of the current operands.
   always_comb begin
      sa     = a_i[63];
      sb     = b_i[63];
      ea     = a_i[62:52];
      eb     = b_i[62:52];
      fa     = a_i[51:0];
      fb     = b_i[51:0];
      s_res  = sa ^ sb;
      a_nan  = (ea == 11'h7FF) && (fa != '0);
      b_nan  = (eb == 11'h7FF) && (fb != '0);
      a_inf  = (ea == 11'h7FF) && (fa == '0);
      b_inf  = (eb == 11'h7FF) && (fb == '0);
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      prod   = {53'd0, 1'b1, fa} * {53'd0, 1'b1, fb};
      exp_s  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 14'sd1023;
      // Normalise on the product MSB; the hidden bit is dropped here so only
      // the 52 fraction bits take part in rounding.
      if (prod[105]) begin
         frac_t = prod[104:53];
         grd    = prod[52];
         stk    = |prod[51:0];
         exp_s  = exp_s + 14'sd1;
      end else begin
         frac_t = prod[103:52];
         grd    = prod[51];
         stk    = |prod[50:0];
      end
      rnd             = grd & (stk | frac_t[0]);
      {carry, frac_r} = {1'b0, frac_t} + {52'd0, rnd};
      if (carry) begin
         exp_s = exp_s + 14'sd1;
      end

      if (a_nan || b_nan) begin
         res_d = 64'h7FF8000000000000;
      end else if (a_inf || b_inf) begin
         if (a_zero || b_zero) res_d = 64'h7FF8000000000000;
         else                  res_d = {s_res, 11'h7FF, 52'd0};
      end else if (a_zero || b_zero) begin
         res_d = {s_res, 63'd0};
      end else if (exp_s >= 14'sd2047) begin
         res_d = {s_res, 11'h7FF, 52'd0};
      end else if (exp_s <= 14'sd0) begin
         res_d = {s_res, 63'd0};
      end else begin
         res_d = {s_res, exp_s[10:0], frac_r};
      end
   end

   // Accept one operation when idle, then count down to the finish pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         res_q  <= '0;
      end else if (valid_i && !busy_q) begin
         busy_q <= 1'b1;
         cnt_q  <= 8'(LATENCY - 1);
         res_q  <= res_d;
      end else if (busy_q) begin
         if (cnt_q == '0) busy_q <= 1'b0;
         else             cnt_q  <= cnt_q - 8'd1;
      end
   end

   assign ready_o  = !busy_q;
   assign finish_o = busy_q && (cnt_q == '0);
   assign result_o = res_q;

endmodule

// File: rtl/kf_time_param_gen.sv
// kf_time_param_gen: turns a sample interval dt into delta_t, 0.5*dt^2 and
// 0.5*dt^3 using one shared fp_multiplier sequenced by a serial FSM.
// Outputs only change together in S_DONE, so downstream CMUs never see a
// mixed old/new set.
// Optional feature macro: KF_TPG_CACHE_EN -- when defined, a dt identical to
// the last completed delta_t skips the multiplies and rewrites the held set.
module kf_time_param_gen
   import kf_pkg::*;
#(
   parameter int unsigned          DBL_WIDTH  = 64,
   parameter logic [DBL_WIDTH-1:0] HALF_CONST = 64'h3FE0000000000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DBL_WIDTH-1:0] dt_in,
   input  logic                 dt_valid,
   output logic                 dt_ready,
   output logic [DBL_WIDTH-1:0] delta_t,
   output logic [DBL_WIDTH-1:0] half_dt2,
   output logic [DBL_WIDTH-1:0] half_dt3,
   output logic                 valid_out,
   output logic                 params_valid
);

   kf_tpg_state_e        state_q, state_d;
   logic [DBL_WIDTH-1:0] dt_q, sq_q, h2_q, h3_q;
   logic [DBL_WIDTH-1:0] delta_t_q, half_dt2_q, half_dt3_q;
   logic                 valid_out_q, params_valid_q;
   logic                 armed_q;
   logic                 accept, cache_hit;

   logic                 mul_valid, mul_ready, mul_finish;
   logic [DBL_WIDTH-1:0] mul_a, mul_b, mul_res;

   // armed_q keeps dt_ready low while reset is held and for no longer.
   assign dt_ready = (state_q == S_IDLE) && armed_q;
   assign accept   = dt_valid && dt_ready;

   // Detect a repeat of the last completed dt.
   always_comb begin
`ifdef KF_TPG_CACHE_EN
      cache_hit = params_valid_q && (dt_in == delta_t_q);
`else
      cache_hit = 1'b0;
`endif
   end

   fp_multiplier #(
      .LATENCY (MUL_LATENCY)
   ) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_i      (mul_a),
      .b_i      (mul_b),
      .valid_i  (mul_valid),
      .ready_o  (mul_ready),
      .finish_o (mul_finish),
      .result_o (mul_res)
   );

   // Next-state, operand select and one-cycle multiplier valid pulse.
   always_comb begin
      state_d   = state_q;
      mul_valid = 1'b0;
      mul_a     = dt_q;
      mul_b     = dt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = cache_hit ? S_DONE : S_SQ_ISSUE;
         end
         S_SQ_ISSUE: begin
            if (mul_ready) begin
               mul_valid = 1'b1;
               state_d   = S_SQ_WAIT;
            end
         end
         S_SQ_WAIT: begin
            if (mul_finish) state_d = S_HALF_ISSUE;
         end
         S_HALF_ISSUE: begin
            mul_a = sq_q;
            mul_b = HALF_CONST;
            if (mul_ready) begin
               mul_valid = 1'b1;
               state_d   = S_HALF_WAIT;
            end
         end
         S_HALF_WAIT: begin
            if (mul_finish) state_d = S_CUBE_ISSUE;
         end
         S_CUBE_ISSUE: begin
            mul_a = h2_q;
            mul_b = dt_q;
            if (mul_ready) begin
               mul_valid = 1'b1;
               state_d   = S_CUBE_WAIT;
            end
         end
         S_CUBE_WAIT: begin
            if (mul_finish) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Operand latch and intermediate results captured on multiplier finish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         dt_q    <= FP_ZERO;
         sq_q    <= FP_ZERO;
         h2_q    <= FP_ZERO;
         h3_q    <= FP_ZERO;
      end else begin
         armed_q <= 1'b1;
         if (accept) dt_q <= dt_in;
         if (mul_finish) begin
            unique case (state_q)
               S_SQ_WAIT:   sq_q <= mul_res;
               S_HALF_WAIT: h2_q <= mul_res;
               S_CUBE_WAIT: h3_q <= mul_res;
               default: ;
            endcase
         end
      end
   end

   // Output set is committed as a whole in S_DONE and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delta_t_q      <= FP_ZERO;
         half_dt2_q     <= FP_ZERO;
         half_dt3_q     <= FP_ZERO;
         valid_out_q    <= 1'b0;
         params_valid_q <= 1'b0;
      end else begin
         valid_out_q <= (state_q == S_DONE);
         if (state_q == S_DONE) begin
            delta_t_q      <= dt_q;
            half_dt2_q     <= h2_q;
            half_dt3_q     <= h3_q;
            params_valid_q <= 1'b1;
         end
      end
   end

   assign delta_t      = delta_t_q;
   assign half_dt2     = half_dt2_q;
   assign half_dt3     = half_dt3_q;
   assign valid_out    = valid_out_q;
   assign params_valid = params_valid_q;

endmodule

// File: tb/tb_kf_time_param_gen.sv
// tb_kf_time_param_gen: scoreboard bench for kf_time_param_gen. Expected
// parameter sets come from a real-arithmetic model and are queued at accept,
// then popped and compared when valid_out pulses. Honours KF_TPG_CACHE_EN.
module tb_kf_time_param_gen;
   import kf_pkg::*;

`ifdef KF_TPG_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   localparam int unsigned FULL_LAT = 3 * (1 + MUL_LATENCY) + 2;

   typedef struct {
      logic [63:0] d;
      logic [63:0] h2;
      logic [63:0] h3;
      int unsigned acc;
      int unsigned mul_base;
      bit          hit;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] dt_in = '0;
   logic        dt_valid = 1'b0;
   logic        dt_ready, valid_out, params_valid;
   logic [63:0] delta_t, half_dt2, half_dt3;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned cyc = 0;
   int unsigned mul_total = 0;
   logic [63:0] mdl_dt = '0, mdl_h2 = '0, mdl_h3 = '0;
   logic        mdl_pv = 1'b0;
   logic [63:0] last_dt = '0;
   bit          have_last = 1'b0;

   kf_time_param_gen #(
      .DBL_WIDTH  (64),
      .HALF_CONST (FP_HALF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dt_in        (dt_in),
      .dt_valid     (dt_valid),
      .dt_ready     (dt_ready),
      .delta_t      (delta_t),
      .half_dt2     (half_dt2),
      .half_dt3     (half_dt3),
      .valid_out    (valid_out),
      .params_valid (params_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [63:0] d);
      exp_t e;
      real  r, sq, h2, h3;
      r    = $bitstoreal(d);
      sq   = r * r;
      h2   = sq * 0.5;
      h3   = h2 * r;
      e.d  = d;
      e.h2 = $realtobits(h2);
      e.h3 = $realtobits(h3);
      e.acc = 0;
      e.mul_base = 0;
      e.hit = 1'b0;
      return e;
   endfunction

   // Present dt, wait (bounded) for dt_ready, queue the expectation at accept.
   task automatic send(input logic [63:0] d, input bit expect_busy);
      exp_t e;
      bit   done;
      done = 1'b0;
      @(negedge clk);
      dt_in    = d;
      dt_valid = 1'b1;
      if (expect_busy) check("busy_ready", {63'd0, dt_ready}, 64'd0);
      for (int i = 0; i < 200 && !done; i++) begin
         if (i > 0) @(negedge clk);
         if (dt_ready) begin
            e          = model(d);
            e.acc      = cyc;
            e.mul_base = mul_total;
            e.hit      = CACHE && have_last && (d == last_dt);
            sb.push_back(e);
            last_dt    = d;
            have_last  = 1'b1;
            done       = 1'b1;
         end
      end
      check("accepted", {63'd0, done}, 64'd1);
      @(posedge clk);
      #1 dt_valid = 1'b0;
   endtask

   // Monitor: count mul pulses, score completed sets, check held outputs.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dut.mul_valid) mul_total++;
         if (valid_out) begin
            if (sb.size() == 0) begin
               check("spurious_valid", {63'd0, valid_out}, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("latency", 64'(cyc - mon_e.acc), mon_e.hit ? 64'd2 : 64'(FULL_LAT));
               check("mul_count", 64'(mul_total - mon_e.mul_base), mon_e.hit ? 64'd0 : 64'd3);
               mdl_dt = mon_e.d;
               mdl_h2 = mon_e.h2;
               mdl_h3 = mon_e.h3;
               mdl_pv = 1'b1;
            end
         end
         check("delta_t", delta_t, mdl_dt);
         check("half_dt2", half_dt2, mdl_h2);
         check("half_dt3", half_dt3, mdl_h3);
         check("params_valid", {63'd0, params_valid}, {63'd0, mdl_pv});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ready", {63'd0, dt_ready}, 64'd0);
      check("rst_valid_out", {63'd0, valid_out}, 64'd0);
      check("rst_params_valid", {63'd0, params_valid}, 64'd0);
      check("rst_delta_t", delta_t, 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 check("ready_after_rst", {63'd0, dt_ready}, 64'd1);

      // Second request arrives mid-computation and is taken back-to-back.
      send(64'h3FF0000000000000, 1'b0);
      send(64'h4000000000000000, 1'b1);
      send(64'h0000000000000000, 1'b0);
      send(64'h8000000000000000, 1'b0);
      send(64'h3FB999999999999A, 1'b0);
      send(64'hC004000000000000, 1'b0);
      send(64'h400D99999999999A, 1'b0);
      send(64'h4000000000000000, 1'b0);
      send(64'h4000000000000000, 1'b0);

      // Reset during the cube step discards the in-flight result.
      send(64'h4008000000000000, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (dut.state_q == S_CUBE_WAIT) seen = 1'b1;
      end
      check("reached_cube_wait", {63'd0, seen}, 64'd1);
      #2 rst_n = 1'b0;
      sb.delete();
      mdl_dt    = '0;
      mdl_h2    = '0;
      mdl_h3    = '0;
      mdl_pv    = 1'b0;
      have_last = 1'b0;
      @(negedge clk);
      check("midrst_ready", {63'd0, dt_ready}, 64'd0);
      check("midrst_delta_t", delta_t, 64'd0);
      check("midrst_half_dt3", half_dt3, 64'd0);
      check("midrst_params_valid", {63'd0, params_valid}, 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 check("midrst_ready_release", {63'd0, dt_ready}, 64'd1);
      send(64'h4000000000000000, 1'b0);

      for (int i = 0; i < 500 && sb.size() > 0; i++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
